// File: rtl/key_counter_display_if.sv
// Pushbutton inputs and display/counter outputs of the key counter.
interface key_counter_display_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          KEY;
    logic [7*DIGITS-1:0] HEX;
    logic [4*DIGITS-1:0] COUNT;
    logic                WRAP;

    modport master (output KEY, input HEX, COUNT, WRAP);
    modport slave  (input KEY, output HEX, COUNT, WRAP);
endinterface

// File: rtl/key_counter_display.sv
// Debounced four-key up/down BCD or hex counter driving active-low seven-segment digits.
module key_counter_display #(
    parameter int DIGITS          = 4,
    parameter int HEX_MODE        = 0,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLANK_LZ        = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    key_counter_display_if.slave  bus
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     LIMIT    = (HEX_MODE != 0) ? 4'hF : 4'h9;
    localparam logic [6:0]     SEG_ZERO = 7'b0000001;
    localparam logic [6:0]     SEG_BLNK = 7'b1111111;
    localparam logic [6:0]     UPPER_RST = (BLANK_LZ != 0) ? SEG_BLNK : SEG_ZERO;

    logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]          level_q, level_d, press_q, press_d;
    logic [CW-1:0]       db_cnt_q [4];
    logic [CW-1:0]       db_cnt_d [4];
    logic [4*DIGITS-1:0] count_q, count_d, inc_val, dec_val;
    logic                wrap_q, wrap_d, inc_wrap, dec_wrap;
    logic                disp_en_q, disp_en_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        sync1_d = bus.KEY;
        sync2_d = sync1_q;
    end

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        press_d = '0;
        for (int k = 0; k < 4; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (sync2_q[k] == level_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DB_LAST) begin
                db_cnt_d[k] = '0;
                level_d[k]  = sync2_q[k];
                press_d[k]  = ~sync2_q[k];
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] nib;
        inc_val = count_q;
        dec_val = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        nib     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (carry) begin
                if (nib == LIMIT) begin
                    inc_val[4*i +: 4] = 4'h0;
                end else begin
                    inc_val[4*i +: 4] = nib + 4'h1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (nib == 4'h0) begin
                    dec_val[4*i +: 4] = LIMIT;
                end else begin
                    dec_val[4*i +: 4] = nib - 4'h1;
                    borrow = 1'b0;
                end
            end
        end
        inc_wrap = carry;
        dec_wrap = borrow;
    end

    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        disp_en_d = disp_en_q ^ press_q[3];
        if (press_q[2]) begin
            count_d = '0;
        end else if (press_q[0] && press_q[1]) begin
            count_d = count_q;
        end else if (press_q[0]) begin
            count_d = inc_val;
            wrap_d  = inc_wrap;
        end else if (press_q[1]) begin
            count_d = dec_val;
            wrap_d  = dec_wrap;
        end
    end

    // Scan from the top digit so higher_zero covers this digit and everything above it.
    always_comb begin
        logic       higher_zero;
        logic [3:0] nib;
        hex_d       = '1;
        higher_zero = 1'b1;
        nib         = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib         = count_q[4*i +: 4];
            higher_zero = higher_zero && (nib == 4'h0);
            if (!disp_en_q)
                hex_d[7*i +: 7] = SEG_BLNK;
            else if ((BLANK_LZ != 0) && (i > 0) && higher_zero)
                hex_d[7*i +: 7] = SEG_BLNK;
            else
                hex_d[7*i +: 7] = seg7(nib);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            level_q   <= 4'hF;
            press_q   <= '0;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            disp_en_q <= 1'b1;
            for (int i = 0; i < DIGITS; i++)
                hex_q[7*i +: 7] <= (i == 0) ? SEG_ZERO : UPPER_RST;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            for (int k = 0; k < 4; k++) db_cnt_q[k] <= db_cnt_d[k];
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            disp_en_q <= disp_en_d;
            hex_q     <= hex_d;
        end
    end

    assign bus.HEX   = hex_q;
    assign bus.COUNT = count_q;
    assign bus.WRAP  = wrap_q;

endmodule

// File: tb/tb_key_counter_display.sv
// Directed bench: decimal and hex instances, DIGITS=2, DEBOUNCE_CYCLES=4, leading-zero blanking on.
module tb_key_counter_display;

    localparam int DC = 4;
    localparam logic [6:0] S_0 = 7'b0000001;
    localparam logic [6:0] S_1 = 7'b1001111;
    localparam logic [6:0] S_9 = 7'b0000100;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wrap_cnt_dec = 0;
    int   wb;

    key_counter_display_if #(.DIGITS(2)) dec_if ();
    key_counter_display_if #(.DIGITS(2)) hex_if ();

    key_counter_display #(.DIGITS(2), .HEX_MODE(0), .DEBOUNCE_CYCLES(DC), .BLANK_LZ(1)) dut_dec (
        .CLOCK_50(clk), .reset(rst), .bus(dec_if)
    );
    key_counter_display #(.DIGITS(2), .HEX_MODE(1), .DEBOUNCE_CYCLES(DC), .BLANK_LZ(1)) dut_hex (
        .CLOCK_50(clk), .reset(rst), .bus(hex_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dec_if.WRAP === 1'b1) wrap_cnt_dec++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dec_if.KEY = 4'hF;
        hex_if.KEY = 4'hF;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press_dec(input logic [3:0] mask);
        dec_if.KEY = ~mask;
        tick(10);
        dec_if.KEY = 4'hF;
        tick(10);
    endtask

    task automatic press_hex(input logic [3:0] mask);
        hex_if.KEY = ~mask;
        tick(10);
        hex_if.KEY = 4'hF;
        tick(10);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dec_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", dec_if.COUNT); end
        n_checks++;
        if (dec_if.HEX !== {S_B, S_0}) begin n_fail++; $display("FAIL reset_hex: got %b want %b", dec_if.HEX, {S_B, S_0}); end
        n_checks++;
        if (dec_if.WRAP !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", dec_if.WRAP); end
        n_checks++;
        if (hex_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL reset_count_hex: got %h want 00", hex_if.COUNT); end
    endtask

    task automatic test_latency();
        do_reset();
        dec_if.KEY = 4'hE;
        tick(2 + DC);
        n_checks++;
        if (dec_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL latency_early: got %h want 00", dec_if.COUNT); end
        tick(1);
        n_checks++;
        if (dec_if.COUNT !== 8'h01) begin n_fail++; $display("FAIL latency_count: got %h want 01", dec_if.COUNT); end
        n_checks++;
        if (dec_if.HEX[6:0] !== S_0) begin n_fail++; $display("FAIL latency_hex_early: got %b want %b", dec_if.HEX[6:0], S_0); end
        tick(1);
        n_checks++;
        if (dec_if.HEX !== {S_B, S_1}) begin n_fail++; $display("FAIL latency_hex: got %b want %b", dec_if.HEX, {S_B, S_1}); end
        dec_if.KEY = 4'hF;
        tick(10);
    endtask

    task automatic test_decimal();
        do_reset();
        for (int j = 0; j < 10; j++) press_dec(4'b0001);
        n_checks++;
        if (dec_if.COUNT !== 8'h10) begin n_fail++; $display("FAIL dec_count: got %h want 10", dec_if.COUNT); end
        n_checks++;
        if (dec_if.HEX !== {S_1, S_0}) begin n_fail++; $display("FAIL dec_hex: got %b want %b", dec_if.HEX, {S_1, S_0}); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int j = 0; j < 10; j++) begin
            dec_if.KEY = (j % 2 == 0) ? 4'hE : 4'hF;
            tick(2);
        end
        dec_if.KEY = 4'hE;
        tick(30);
        n_checks++;
        if (dec_if.COUNT !== 8'h01) begin n_fail++; $display("FAIL bounce_count: got %h want 01", dec_if.COUNT); end
        dec_if.KEY = 4'hF;
        tick(10);
    endtask

    task automatic test_wrap();
        do_reset();
        wb = wrap_cnt_dec;
        press_dec(4'b0010);
        n_checks++;
        if (dec_if.COUNT !== 8'h99) begin n_fail++; $display("FAIL wrap_dec_count: got %h want 99", dec_if.COUNT); end
        n_checks++;
        if (wrap_cnt_dec - wb !== 1) begin n_fail++; $display("FAIL wrap_dec_pulse: got %0d cycles want 1", wrap_cnt_dec - wb); end
        n_checks++;
        if (dec_if.HEX !== {S_9, S_9}) begin n_fail++; $display("FAIL wrap_dec_hex: got %b want %b", dec_if.HEX, {S_9, S_9}); end
        wb = wrap_cnt_dec;
        press_dec(4'b0001);
        n_checks++;
        if (dec_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL wrap_inc_count: got %h want 00", dec_if.COUNT); end
        n_checks++;
        if (wrap_cnt_dec - wb !== 1) begin n_fail++; $display("FAIL wrap_inc_pulse: got %0d cycles want 1", wrap_cnt_dec - wb); end
        n_checks++;
        if (dec_if.HEX !== {S_B, S_0}) begin n_fail++; $display("FAIL wrap_inc_hex: got %b want %b", dec_if.HEX, {S_B, S_0}); end
    endtask

    task automatic test_hex();
        do_reset();
        for (int j = 0; j < 26; j++) press_hex(4'b0001);
        n_checks++;
        if (hex_if.COUNT !== 8'h1A) begin n_fail++; $display("FAIL hex_count: got %h want 1a", hex_if.COUNT); end
        n_checks++;
        if (hex_if.HEX !== {S_1, S_A}) begin n_fail++; $display("FAIL hex_hex: got %b want %b", hex_if.HEX, {S_1, S_A}); end
        press_hex(4'b0010);
        n_checks++;
        if (hex_if.COUNT !== 8'h19) begin n_fail++; $display("FAIL hex_dec: got %h want 19", hex_if.COUNT); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_dec(4'b0001);
        press_dec(4'b0001);
        press_dec(4'b0011);
        n_checks++;
        if (dec_if.COUNT !== 8'h02) begin n_fail++; $display("FAIL simul_incdec: got %h want 02", dec_if.COUNT); end
        wb = wrap_cnt_dec;
        press_dec(4'b0101);
        n_checks++;
        if (dec_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL simul_clr: got %h want 00", dec_if.COUNT); end
        n_checks++;
        if (wrap_cnt_dec - wb !== 0) begin n_fail++; $display("FAIL simul_clr_wrap: got %0d pulses want 0", wrap_cnt_dec - wb); end
    endtask

    task automatic test_toggle();
        do_reset();
        press_dec(4'b1000);
        n_checks++;
        if (dec_if.HEX !== 14'h3FFF) begin n_fail++; $display("FAIL toggle_off_hex: got %b want all ones", dec_if.HEX); end
        press_dec(4'b0001);
        n_checks++;
        if (dec_if.COUNT !== 8'h01) begin n_fail++; $display("FAIL toggle_count: got %h want 01", dec_if.COUNT); end
        n_checks++;
        if (dec_if.HEX !== 14'h3FFF) begin n_fail++; $display("FAIL toggle_still_off: got %b want all ones", dec_if.HEX); end
        press_dec(4'b1000);
        n_checks++;
        if (dec_if.HEX !== {S_B, S_1}) begin n_fail++; $display("FAIL toggle_on_hex: got %b want %b", dec_if.HEX, {S_B, S_1}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press_dec(4'b0001);
        press_dec(4'b1000);
        wb = wrap_cnt_dec;
        dec_if.KEY = 4'hE;
        tick(4);
        rst = 1'b1;
        dec_if.KEY = 4'hF;
        tick(2);
        rst = 1'b0;
        tick(20);
        n_checks++;
        if (dec_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL mid_count: got %h want 00", dec_if.COUNT); end
        n_checks++;
        if (dec_if.HEX !== {S_B, S_0}) begin n_fail++; $display("FAIL mid_hex: got %b want %b", dec_if.HEX, {S_B, S_0}); end
        n_checks++;
        if (wrap_cnt_dec - wb !== 0) begin n_fail++; $display("FAIL mid_wrap: got %0d pulses want 0", wrap_cnt_dec - wb); end
        dec_if.KEY = 4'hE;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(DC + 2);
        n_checks++;
        if (dec_if.COUNT !== 8'h00) begin n_fail++; $display("FAIL held_early: got %h want 00", dec_if.COUNT); end
        tick(1);
        n_checks++;
        if (dec_if.COUNT !== 8'h01) begin n_fail++; $display("FAIL held_count: got %h want 01", dec_if.COUNT); end
        dec_if.KEY = 4'hF;
        tick(10);
    endtask

    initial begin
        dec_if.KEY = 4'hF;
        hex_if.KEY = 4'hF;
        test_reset();
        test_latency();
        test_decimal();
        test_bounce();
        test_wrap();
        test_hex();
        test_simultaneous();
        test_toggle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_counter_display.md
KEY_COUNTER_DISPLAY -- requirements
Module: key_counter_display

Interface
REQ-001 Parameter DIGITS, default 4: number of seven-segment digits driven, legal range 1..6.
REQ-002 Parameter HEX_MODE, default 0: 0 = decimal (BCD) counting, 1 = hexadecimal counting.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: number of consecutive stable synchronized samples required to accept a key level change, minimum 2.
REQ-004 Parameter BLANK_LZ, default 1: 1 = leading-zero blanking enabled, 0 = all digits always shown.
REQ-005 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 KEY  input  4  active-low pushbuttons: KEY[0] increment, KEY[1] decrement, KEY[2] clear, KEY[3] display on/off toggle.
REQ-008 HEX  output  7*DIGITS  registered, active-low segments; digit i occupies HEX[7*i+6 : 7*i], bit 7*i+6 = segment a ... bit 7*i = segment g; digit 0 is least significant.
REQ-009 COUNT  output  4*DIGITS  registered counter value, one 4-bit nibble per digit, digit i in COUNT[4*i+3 : 4*i].
REQ-010 WRAP  output  1  registered one-cycle pulse on any wrap-around.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Each key SHALL have an independent debouncer: debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level; any sample equal to it restarts the count.
REQ-013 A press event SHALL be a one-cycle pulse generated on the debounced transition released->pressed; release generates no event; holding a key produces exactly one event.
REQ-014 Latency: key driven low and held -> press pulse at edge 2+DEBOUNCE_CYCLES after first sampling edge; COUNT/WRAP update one edge later; HEX updates one edge after COUNT.
REQ-015 Same-cycle priority: clear > (increment and decrement together = no change) > increment > decrement; the toggle event is independent and may coincide with any of these.
REQ-016 Clear SHALL set COUNT to 0 with no WRAP pulse.
REQ-017 Increment: digit 0 +1, carry ripples; digit limit is 9 (HEX_MODE=0) or F (HEX_MODE=1); at all-digits-at-limit, result is 0 and WRAP pulses.
REQ-018 Decrement: digit 0 -1, borrow ripples; at 0, result is all-digits-at-limit and WRAP pulses.
REQ-019 COUNT SHALL never hold a nibble above 9 when HEX_MODE=0.
REQ-020 Segment patterns (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-021 Blank pattern SHALL be 1111111.
REQ-022 With BLANK_LZ=1, digit i>0 SHALL show blank when it and all higher digits are 0; digit 0 is never lz-blanked.
REQ-023 Toggle event SHALL invert the display-enable flag; while disabled all HEX digits show blank, counting continues, and COUNT/WRAP remain valid.

Reset
REQ-024 On reset high at an edge: COUNT=0, WRAP=0, display-enable=1, all debounced levels = released, debounce counters=0, synchronizer flops=1 (released).
REQ-025 HEX after reset SHALL be digit 0 = 0000001 and all other digits blank (BLANK_LZ=1) or 0000001 (BLANK_LZ=0).
REQ-026 Reset SHALL take effect mid-debounce or mid-count, discarding any pending event; a key held low through reset generates one press event DEBOUNCE_CYCLES+2 edges after reset deasserts.

Verification (DIGITS=2, DEBOUNCE_CYCLES=4, BLANK_LZ=1)
REQ-027 Decimal: reset, press KEY[0] 10 times -> COUNT=0x10, HEX[13:7]=1001111, HEX[6:0]=0000001.
REQ-028 Bounce: KEY[0] toggling every 2 cycles for 20 cycles then held low -> exactly one increment.
REQ-029 Wrap: decimal, press KEY[1] from 0 -> COUNT=0x99, WRAP high exactly one cycle; then KEY[0] -> COUNT=0x00 with WRAP pulse.
REQ-030 Hex: HEX_MODE=1, 26 increments -> COUNT=0x1A, digit 0 = 0001000, digit 1 = 1001111.
REQ-031 Simultaneous: KEY[0]+KEY[1] pressed same cycle -> COUNT unchanged; KEY[0]+KEY[2] -> COUNT=0, no WRAP.
REQ-032 Toggle/reset: KEY[3] press -> all HEX=1111111 while increments still advance COUNT; reset mid-debounce -> COUNT=0, display on, no spurious event.
